// File: rtl/vote_pkg.sv
// vote_pkg: shared state encoding, voter limit and count clamp for the voting pipeline.
package vote_pkg;
  localparam int N_VOTERS_MAX = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;
  function automatic logic [3:0] clamp_voters(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction
endpackage

// File: rtl/round_timer.sv
// round_timer: loadable down-counter that flags the last enabled cycle; a zero load never expires.
module round_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
  // Expiry fires while the counter steps 1 -> 0, so a votes-in-that-cycle still count.
  assign expired_o = en_i && (cnt_q == W'(1));
endmodule

// File: rtl/vote_round_collector.sv
// vote_round_collector: gathers one vote per active voter per round and emits the closed ballot.
module vote_round_collector
  import vote_pkg::*;
#(
  parameter int N_VOTERS  = N_VOTERS_MAX,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [3:0]           num_voters,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [N_VOTERS-1:0]  vote_valid,
  input  logic [N_VOTERS-1:0]  vote_fail,
  output logic                 busy,
  output logic                 ballot_valid,
  output logic [N_VOTERS-1:0]  ballot,
  output logic [N_VOTERS-1:0]  present,
  output logic                 timed_out,
  output logic                 dup_err,
  output logic [3:0]           num_voters_q
);
  state_e state_q;
  logic busy_q, ballot_valid_q, timed_out_q, dup_err_q;
  logic [N_VOTERS-1:0] ballot_q, present_q, fail_q;
  logic [N_VOTERS:0] act_full;
  logic [N_VOTERS-1:0] active, accept, present_d, fail_d;
  logic accept_start, collect, dup_hit, done, expired;
  assign act_full     = ((N_VOTERS+1)'(1) << num_voters_q) - (N_VOTERS+1)'(1);
  assign active       = act_full[N_VOTERS-1:0];
  assign accept_start = ena && start && state_q == IDLE;
  assign collect      = ena && state_q == COLLECT;
  assign accept       = collect ? (vote_valid & active & ~present_q) : '0;
  assign present_d    = present_q | accept;
  assign fail_d       = fail_q | (accept & vote_fail);
  assign dup_hit      = collect && |(vote_valid & active & present_q);
  assign done         = (present_d & active) == active;
  round_timer #(.W(TIMEOUT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept_start),
    .val_i    (timeout),
    .en_i     (collect),
    .expired_o(expired)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      ballot_valid_q <= 1'b0;
      ballot_q       <= '0;
      present_q      <= '0;
      fail_q         <= '0;
      timed_out_q    <= 1'b0;
      dup_err_q      <= 1'b0;
      num_voters_q   <= '0;
    end else if (!ena) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      ballot_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ballot_valid_q <= 1'b0;
          if (start) begin
            num_voters_q <= clamp_voters(num_voters);
            present_q    <= '0;
            fail_q       <= '0;
            dup_err_q    <= 1'b0;
            timed_out_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= COLLECT;
          end
        end
        COLLECT: begin
          present_q <= present_d;
          fail_q    <= fail_d;
          if (dup_hit) dup_err_q <= 1'b1;
          if (done || expired) begin
            ballot_q       <= fail_d | (active & ~present_d);
            timed_out_q    <= !done;
            ballot_valid_q <= 1'b1;
            state_q        <= EMIT;
          end
        end
        default: begin
          ballot_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end
  assign busy         = busy_q;
  assign ballot_valid = ballot_valid_q;
  assign ballot       = ballot_q;
  assign present      = present_q;
  assign timed_out    = timed_out_q;
  assign dup_err      = dup_err_q;
endmodule

// File: tb/tb_vote_round_collector.sv
// tb_vote_round_collector: directed rounds with hand-computed ballots, checked one cycle at a time.
module tb_vote_round_collector;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, start = 1'b0;
  logic [3:0] num_voters = '0;
  logic [7:0] timeout = '0, vote_valid = '0, vote_fail = '0;
  logic busy, ballot_valid, timed_out, dup_err;
  logic [7:0] ballot, present;
  logic [3:0] num_voters_q;
  int n_checks = 0, n_fail = 0;

  vote_round_collector dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .num_voters(num_voters),
    .timeout(timeout), .vote_valid(vote_valid), .vote_fail(vote_fail), .busy(busy),
    .ballot_valid(ballot_valid), .ballot(ballot), .present(present), .timed_out(timed_out),
    .dup_err(dup_err), .num_voters_q(num_voters_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_round(input logic [3:0] n, input logic [7:0] t);
    num_voters = n;
    timeout = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vote(input logic [7:0] v, input logic [7:0] f);
    vote_valid = v;
    vote_fail = f;
  endtask

  initial begin
    #12;
    chk("reset_outputs", {8'h0, busy, ballot_valid, timed_out, dup_err, num_voters_q, ballot, present}, 32'h0);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();
    // All five vote at t+1, voters 1 and 3 fail
    open_round(4'd5, 8'd10);
    chk("t1_busy", busy, 1);
    chk("t1_bv_early", ballot_valid, 0);
    vote(8'h1F, 8'h0A);
    tick();
    vote(8'h00, 8'h00);
    chk("t1_bv", ballot_valid, 1);
    chk("t1_ballot", ballot, 8'h0A);
    chk("t1_present", present, 8'h1F);
    chk("t1_to", timed_out, 0);
    tick();
    chk("t1_bv_drop", ballot_valid, 0);
    chk("t1_busy_drop", busy, 0);
    chk("t1_ballot_hold", ballot, 8'h0A);
    // Timeout 3 with voters 0 and 2 only; a stray start mid-round is ignored
    open_round(4'd4, 8'd3);
    vote(8'h05, 8'h00);
    tick();
    vote(8'h00, 8'h00);
    start = 1'b1;
    num_voters = 4'd1;
    chk("t2_bv_t2", ballot_valid, 0);
    tick();
    start = 1'b0;
    chk("t2_bv_t3", ballot_valid, 0);
    chk("t2_nvq_kept", num_voters_q, 4'd4);
    tick();
    chk("t2_bv", ballot_valid, 1);
    chk("t2_ballot", ballot, 8'h0A);
    chk("t2_present", present, 8'h05);
    chk("t2_to", timed_out, 1);
    tick();
    // Duplicate vote on voter 1 keeps first (pass) value
    open_round(4'd3, 8'd0);
    vote(8'h02, 8'h00);
    tick();
    vote(8'h07, 8'h02);
    chk("t3_bv_t2", ballot_valid, 0);
    tick();
    vote(8'h00, 8'h00);
    chk("t3_bv", ballot_valid, 1);
    chk("t3_ballot", ballot, 8'h00);
    chk("t3_present", present, 8'h07);
    chk("t3_dup", dup_err, 1);
    tick();
    chk("t3_dup_sticky", dup_err, 1);
    // Count 12 clamps to 8
    open_round(4'd12, 8'd0);
    chk("t4_nvq", num_voters_q, 4'd8);
    chk("t4_dup_cleared", dup_err, 0);
    vote(8'hFF, 8'h81);
    tick();
    vote(8'h00, 8'h00);
    chk("t4_bv", ballot_valid, 1);
    chk("t4_ballot", ballot, 8'h81);
    chk("t4_present", present, 8'hFF);
    tick();
    // Zero voters: immediate close, strobes ignored
    open_round(4'd0, 8'd5);
    chk("t5_nvq", num_voters_q, 4'd0);
    vote(8'hFF, 8'hFF);
    tick();
    vote(8'h00, 8'h00);
    chk("t5_bv", ballot_valid, 1);
    chk("t5_ballot", ballot, 8'h00);
    chk("t5_present", present, 8'h00);
    chk("t5_dup", dup_err, 0);
    tick();
    // Completion and timeout coincide at t+2
    open_round(4'd2, 8'd2);
    vote(8'h01, 8'h00);
    tick();
    vote(8'h02, 8'h02);
    tick();
    vote(8'h00, 8'h00);
    chk("t6_bv", ballot_valid, 1);
    chk("t6_to", timed_out, 0);
    chk("t6_ballot", ballot, 8'h02);
    tick();
    // ena dropped mid-COLLECT: back to IDLE without a pulse, ballot untouched
    open_round(4'd3, 8'd0);
    vote(8'h01, 8'h01);
    tick();
    vote(8'h00, 8'h00);
    ena = 1'b0;
    tick();
    chk("t7_busy", busy, 0);
    chk("t7_bv", ballot_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t7_start_gated", busy, 0);
    ena = 1'b1;
    vote(8'h06, 8'h00);
    tick();
    vote(8'h00, 8'h00);
    chk("t7_bv_after", ballot_valid, 0);
    chk("t7_ballot_kept", ballot, 8'h02);
    // Async reset mid-COLLECT, then a fresh round
    open_round(4'd4, 8'd0);
    vote(8'h03, 8'h01);
    tick();
    vote(8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_reset_outputs", {8'h0, busy, ballot_valid, timed_out, dup_err, num_voters_q, ballot, present}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    open_round(4'd1, 8'd0);
    chk("t8_busy", busy, 1);
    vote(8'h01, 8'h01);
    tick();
    vote(8'h00, 8'h00);
    chk("t8_bv", ballot_valid, 1);
    chk("t8_ballot", ballot, 8'h01);
    chk("t8_present", present, 8'h01);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vote_round_collector.md
# vote_round_collector

Collects one ballot per voting round from up to eight voters and hands the closed ballot to the downstream fail-count/threshold voter. A round opens on `start`, records at most one vote per active voter, and closes when every active voter has voted or a programmable timeout expires. Missing votes are reported as fails. Sits directly upstream of the voter; its `ballot` drives the voter's `ui_in`, and its `num_voters_q` drives the voter's voter-count field.

## Interface
- `N_VOTERS`, 8, maximum voter count; ballot width.
- `TIMEOUT_W`, 8, width of the timeout counter.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design enable; low aborts any open round.
- `start`  in  1  single-cycle pulse that opens a round; honoured only in IDLE with `ena`=1.
- `num_voters`  in  4  active voter count, sampled on accepted `start`; values >8 are clamped to 8.
- `timeout`  in  TIMEOUT_W  COLLECT-cycle budget, sampled on accepted `start`; 0 means no timeout.
- `vote_valid`  in  N_VOTERS  per-voter vote strobe.
- `vote_fail`  in  N_VOTERS  per-voter vote value (1 = fail), qualified by `vote_valid`.
- `busy`  out  1  high in COLLECT and EMIT.
- `ballot_valid`  out  1  one-cycle pulse; ballot outputs are valid.
- `ballot`  out  N_VOTERS  fail bits; inactive voters read 0, active non-voters read 1.
- `present`  out  N_VOTERS  voters that voted this round.
- `timed_out`  out  1  round closed by timeout.
- `dup_err`  out  1  sticky flag: a voter strobed again in the same round; cleared on the next accepted `start`.
- `num_voters_q`  out  4  clamped count for the current round.

## Operation
- FSM states: IDLE, COLLECT, EMIT.
- IDLE, with `start`&`ena`: latch `num_voters_q` (clamped) and the timer; clear `present`, the fail vector, `dup_err` and `timed_out`; go to COLLECT. `start` in other states is ignored.
- COLLECT, each cycle, for each active voter i (i < `num_voters_q`):
  - `vote_valid[i]` with `present[i]`=0: set `present[i]` and record `vote_fail[i]`.
  - `vote_valid[i]` with `present[i]`=1: keep the first vote and set `dup_err`.
- Strobes on inactive voters are ignored silently.
- COLLECT close, evaluated on next-state values, so votes in the closing cycle count:
  - If all active voters are present, go to EMIT with `timed_out`=0.
  - Otherwise, if `timeout`≠0 and the timer reaches 0, go to EMIT with `timed_out`=1.
  - Completion takes priority over timeout in the same cycle.
- `ballot` = recorded fails OR (active & ~present); computed on entry to EMIT.
- EMIT: `ballot_valid`=1 for exactly one cycle, then IDLE. `ballot`, `present`, `timed_out` and `dup_err` hold until the next accepted `start`.
- `num_voters_q`=0: the round completes in its first COLLECT cycle with `ballot`=0 and `present`=0.
- `ena` low in COLLECT or EMIT: return to IDLE next cycle with no `ballot_valid`; the ballot registers are left unchanged.
- Async reset mid-round: FSM goes to IDLE immediately. All outputs reset to 0: `busy`, `ballot_valid`, `ballot`, `present`, `timed_out`, `dup_err`, `num_voters_q`.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `start` accepted at cycle t puts the block in COLLECT at t+1.
- If all votes arrive at t+1, `ballot_valid` is high at t+2 (minimum latency 2).
- Timeout T: COLLECT occupies t+1..t+T; votes in t+T are counted; `ballot_valid` is high at t+T+1.
- `busy` rises at t+1 and falls in the cycle after `ballot_valid`.
- Back-to-back rounds: the earliest next `start` is accepted in the cycle after EMIT.

## Structure
- Shared package `vote_pkg`: state enum (IDLE/COLLECT/EMIT), `N_VOTERS_MAX`=8, and a `clamp_voters` function (4-bit in, 4-bit out, saturating at 8). The voter stage uses the same package.
- The active mask (`(1<<num_voters_q)-1`) is derived locally.
- One natural sub-module, `round_timer`: load, decrement-while-enabled, `expired` output, disabled when the load value is 0.

## Test plan
- `num_voters`=5, `timeout`=10, all five vote at t+1 with fails on voters 1 and 3 -> `ballot_valid` at t+2, `ballot`=8'h0A, `present`=8'h1F, `timed_out`=0.
- `num_voters`=4, `timeout`=3, only voters 0 and 2 vote (pass) -> `ballot_valid` at t+4, `ballot`=8'h0A, `present`=8'h05, `timed_out`=1.
- `num_voters`=3, voter 1 votes pass at t+1 then fail at t+2, others vote at t+2 -> voter 1 recorded as pass, `dup_err`=1, ballot at t+3.
- `num_voters`=12 and strobes on all 8 voters -> `num_voters_q`=8 and the round completes normally; with `num_voters`=0 -> ballot at t+2 equal to 0.
- Completion and timeout in the same cycle -> `timed_out`=0.
- `ena` dropped mid-COLLECT -> IDLE, no pulse.
- `rst_n` asserted mid-COLLECT -> all outputs 0 immediately; a new `start` after release works.
